card_deck_shuffler: RTL and testbench

//  Builds a randomised 4x4 memory-game board: 16 cards, 8 pairs, values 0..7 each exactly twice.

---
 rtl/card_deck_shuffler.sv | 129 ++++++++++++
 tb/tb_card_deck_shuffler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_deck_shuffler.sv
// card_deck_shuffler: free-running Galois LFSR feeding an in-place Fisher-Yates shuffle of a memory-game board.
// Optional feature macro SHUFFLE_SEED_LOAD_EN adds seed_we/seed_val to reload the LFSR while idle.
module card_deck_shuffler #(
  parameter int                N_CARDS = 16,
  parameter int                VAL_W   = 3,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                MAX_REJ = 7,
  localparam int               IDX_W   = $clog2(N_CARDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shuffle_req,
`ifdef SHUFFLE_SEED_LOAD_EN
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed_val,
`endif
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [VAL_W-1:0]  rd_val,
  output logic              busy,
  output logic              done,
  output logic              board_valid
);

  localparam int                REJ_W     = $clog2(MAX_REJ + 1);
  localparam logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(16'hB400);
  localparam logic [LFSR_W-1:0] SEED_NZ   = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CARDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHUF, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr, lfsr_next;
  logic [VAL_W-1:0]   board [N_CARDS];
  logic [IDX_W-1:0]   idx;
  logic [REJ_W-1:0]   rej;
  logic [IDX_W-1:0]   r;
  logic               accept, take, swap;

  assign r      = lfsr[IDX_W-1:0];
  assign rd_val = board[rd_idx];

  // The LFSR never stops so the board depends on when START was pressed.
  always_comb begin
    lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
`ifdef SHUFFLE_SEED_LOAD_EN
    if (state_q == S_IDLE && seed_we)
      lfsr_next = (seed_val == '0) ? LFSR_W'(1) : seed_val;
`endif
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    take    = 1'b0;
    swap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A request coinciding with the done pulse belongs to the old shuffle.
        if (shuffle_req && !done) begin
          accept  = 1'b1;
          state_d = S_SHUF;
        end
      end
      S_SHUF: begin
        if (r <= idx) begin
          swap = 1'b1;
          take = 1'b1;
        end else if (rej == REJ_W'(MAX_REJ)) begin
          take = 1'b1;
        end
        if (take && idx == IDX_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes the in-place swap below work.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= SEED_NZ;
      busy        <= 1'b0;
      done        <= 1'b0;
      board_valid <= 1'b0;
      idx         <= IDX_LAST;
      rej         <= '0;
      // NOTE: the board array is reset deliberately: the sorted layout is the
      // documented reset state and the permutation invariant depends on it.
      for (int k = 0; k < N_CARDS; k++) board[k] <= VAL_W'(k >> 1);
    end else begin
      lfsr <= lfsr_next;
      done <= 1'b0;
      if (accept) begin
        for (int k = 0; k < N_CARDS; k++) board[k] <= VAL_W'(k >> 1);
        board_valid <= 1'b0;
        busy        <= 1'b1;
        idx         <= IDX_LAST;
        rej         <= '0;
      end
      if (state_q == S_SHUF) begin
        if (swap) begin
          board[idx] <= board[r];
          board[r]   <= board[idx];
        end
        if (take) begin
          idx <= idx - IDX_W'(1);
          rej <= '0;
        end else begin
          rej <= rej + REJ_W'(1);
        end
      end
      if (state_q == S_DONE) begin
        done        <= 1'b1;
        busy        <= 1'b0;
        board_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_card_deck_shuffler.sv
// Directed bench for card_deck_shuffler: reset state, shuffles vs a behavioural golden model,
// request filtering, mid-shuffle reset and (with SHUFFLE_SEED_LOAD_EN) seed reloading.
module tb_card_deck_shuffler;

  logic        clk = 1'b0;
  logic        rst;
  logic        shuffle_req;
  logic [3:0]  rd_idx;
  logic [2:0]  rd_val;
  logic        busy, done, board_valid;
`ifdef SHUFFLE_SEED_LOAD_EN
  logic        seed_we;
  logic [15:0] seed_val;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  gold [16];
  logic [2:0]  gold_first [16];
  int          gold_cycles;
  int          lat;
  int          hist [8];
  int          diff;
  int          done_seen;

  card_deck_shuffler dut (
    .clk         (clk),
    .rst         (rst),
    .shuffle_req (shuffle_req),
`ifdef SHUFFLE_SEED_LOAD_EN
    .seed_we     (seed_we),
    .seed_val    (seed_val),
`endif
    .rd_idx      (rd_idx),
    .rd_val      (rd_val),
    .busy        (busy),
    .done        (done),
    .board_valid (board_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference LFSR, tracking the free-running generator edge by edge.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
`ifdef SHUFFLE_SEED_LOAD_EN
    else if (seed_we) m_lfsr <= (seed_val == 16'h0) ? 16'h0001 : seed_val;
`endif
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  // Fisher-Yates with rejection, starting from the LFSR value seen in the first SHUF cycle.
  function automatic void golden(input logic [15:0] l0);
    logic [15:0] l = l0;
    int i = 15;
    int rej = 0;
    int r;
    logic [2:0] t;
    logic stepped;
    for (int k = 0; k < 16; k++) gold[k] = 3'(k / 2);
    gold_cycles = 0;
    for (int c = 0; c < 200; c++) begin
      r = int'(l[3:0]);
      gold_cycles++;
      stepped = 1'b0;
      if (r <= i) begin
        t = gold[i]; gold[i] = gold[r]; gold[r] = t;
        stepped = 1'b1;
      end else if (rej < 7) begin
        rej++;
      end else begin
        stepped = 1'b1;
      end
      l = lfsr_step(l);
      if (stepped) begin
        if (i == 1) break;
        i--;
        rej = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_board_gold(input string tag);
    for (int v = 0; v < 8; v++) hist[v] = 0;
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k);
      #1;
      check($sformatf("%s_idx%0d", tag, k), 32'(rd_val), 32'(gold[k]));
      hist[rd_val] = hist[rd_val] + 1;
    end
    for (int v = 0; v < 8; v++)
      check($sformatf("%s_count_val%0d", tag, v), 32'(hist[v]), 32'd2);
  endtask

  task automatic check_board_sorted(input string tag);
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k);
      #1;
      check($sformatf("%s_idx%0d", tag, k), 32'(rd_val), 32'(k / 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    shuffle_req = 1'b0;
    rd_idx = '0;
`ifdef SHUFFLE_SEED_LOAD_EN
    seed_we = 1'b0;
    seed_val = '0;
`endif

    // Reset state.
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(board_valid), 32'd0);
    check_board_sorted("rst_board");

    // First shuffle from the reset seed.
    repeat (3) tick();
    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    golden(m_lfsr);
    check("s1_busy_start", 32'(busy), 32'd1);
    check("s1_valid_low", 32'(board_valid), 32'd0);
    wait_done("s1");
    check("s1_latency", 32'(lat), 32'(gold_cycles + 1));
    check("s1_latency_min", 32'(lat >= 16), 32'd1);
    check("s1_latency_max", 32'(lat <= 122), 32'd1);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_valid", 32'(board_valid), 32'd1);
    shuffle_req = 1'b1;   // same cycle as the done pulse: must be ignored
    tick();
    shuffle_req = 1'b0;
    check("s1_done_one_cycle", 32'(done), 32'd0);
    check("s1_req_on_done_ignored", 32'(busy), 32'd0);
    check("s1_valid_hold", 32'(board_valid), 32'd1);
    check_board_gold("s1_board");
    for (int k = 0; k < 16; k++) gold_first[k] = gold[k];

    // Second shuffle, request held high for the whole shuffle.
    tick();
    shuffle_req = 1'b1;
    tick();
    golden(m_lfsr);
    check("s2_busy_start", 32'(busy), 32'd1);
    check("s2_valid_drop", 32'(board_valid), 32'd0);
    wait_done("s2");
    check("s2_latency", 32'(lat), 32'(gold_cycles + 1));
    tick();
    shuffle_req = 1'b0;
    check("s2_single_done", 32'(done), 32'd0);
    check("s2_no_requeue", 32'(busy), 32'd0);
    check_board_gold("s2_board");
    diff = 0;
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k);
      #1;
      if (rd_val !== gold_first[k]) diff++;
    end
    check("s2_differs_from_s1", 32'(diff != 0), 32'd1);

    // Reset five cycles into a shuffle.
    tick();
    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    repeat (5) tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_valid", 32'(board_valid), 32'd0);
    check_board_sorted("mid_rst_board");
    done_seen = 0;
    for (int c = 0; c < 130; c++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);

`ifdef SHUFFLE_SEED_LOAD_EN
    // Seed 0 is coerced to 1; the first candidate uses the loaded seed.
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      seed_val = 16'h0000;
      seed_we = 1'b1;
      shuffle_req = 1'b1;
      tick();
      seed_we = 1'b0;
      shuffle_req = 1'b0;
      golden(16'h0001);
      check($sformatf("seed%0d_busy", pass), 32'(busy), 32'd1);
      wait_done($sformatf("seed%0d", pass));
      check($sformatf("seed%0d_latency", pass), 32'(lat), 32'(gold_cycles + 1));
      tick();
      check_board_gold($sformatf("seed%0d_board", pass));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
